// File: rtl/seq_control_unit.sv
// rtl/seq_control_unit.sv - multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control unit
// Holds the zero flag, HALT state and retired-instruction counter; drives ALU, regfile, PC strobes.
module seq_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic                instr_req,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  output logic [3:0]          alu_op,
  output logic                use_immediate,
  output logic                write_enable,
  output logic                jmp_enable,
  output logic                pc_inc,
  output logic                zero_flag,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALTED
  } state_t;

  state_t state, next_state;
  logic [OPCODE_W-1:0] ir;
  logic [3:0] lo;
  logic upper_zero;
  logic is_alu, is_jmp, is_jnz, is_jz, is_halt, taken, handshake;

  assign lo = ir[3:0];

  // Opcodes with any bit set above the decoded nibble are treated as NOP.
  generate
    if (OPCODE_W > 4) begin : g_wide
      assign upper_zero = ~|ir[OPCODE_W-1:4];
    end else begin : g_narrow
      assign upper_zero = 1'b1;
    end
  endgenerate

  assign is_alu  = upper_zero && (lo <= 4'd9);
  assign is_jmp  = upper_zero && (lo == 4'd12);
  assign is_jnz  = upper_zero && (lo == 4'd13);
  assign is_jz   = upper_zero && (lo == 4'd14);
  assign is_halt = upper_zero && (lo == 4'd15);
  assign taken   = is_jmp || (is_jnz && !zero_flag) || (is_jz && zero_flag);

  assign handshake = instr_req && instr_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      ir        <= '0;
      zero_flag <= 1'b0;
      retired   <= '0;
      instr_req <= 1'b0;
    end else begin
      state <= next_state;
      // Registered so instr_req stays low while rst is high and rises one edge later.
      instr_req <= (next_state == S_FETCH);
      if (handshake) begin
        ir <= opcode;
      end
      if (state == S_EXECUTE && is_alu) begin
        zero_flag <= alu_zero;
      end
      if (state == S_WRITEBACK && !is_halt) begin
        retired <= retired + RETIRE_W'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:     if (handshake) next_state = S_DECODE;
      S_DECODE:    next_state = S_EXECUTE;
      S_EXECUTE:   next_state = S_WRITEBACK;
      S_WRITEBACK: next_state = is_halt ? S_HALTED : S_FETCH;
      S_HALTED:    next_state = S_HALTED;
      default:     next_state = S_FETCH;
    endcase
  end

  always_comb begin
    alu_op        = 4'd0;
    use_immediate = 1'b0;
    write_enable  = 1'b0;
    jmp_enable    = 1'b0;
    pc_inc        = 1'b0;
    halted        = 1'b0;
    case (state)
      S_DECODE, S_EXECUTE: begin
        if (is_alu) begin
          alu_op        = lo;
          use_immediate = lo[0];
        end
      end
      S_WRITEBACK: begin
        if (is_alu) begin
          alu_op        = lo;
          use_immediate = lo[0];
        end
        write_enable = is_alu;
        jmp_enable   = taken;
        pc_inc       = !is_halt && !taken;
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// tb/tb_seq_control_unit.sv - scoreboard bench for seq_control_unit
// Runs with OPCODE_W = 6 and RETIRE_W = 2 so upper-bit NOPs and counter wrap are reachable.
module tb_seq_control_unit;

  logic       clk;
  logic       rst;
  logic       instr_req;
  logic       instr_valid;
  logic [5:0] opcode;
  logic       alu_zero;
  logic [3:0] alu_op;
  logic       use_immediate;
  logic       write_enable;
  logic       jmp_enable;
  logic       pc_inc;
  logic       zero_flag;
  logic       halted;
  logic [1:0] retired;

  seq_control_unit #(.OPCODE_W(6), .RETIRE_W(2)) dut (
    .clk(clk), .rst(rst), .instr_req(instr_req), .instr_valid(instr_valid),
    .opcode(opcode), .alu_zero(alu_zero), .alu_op(alu_op),
    .use_immediate(use_immediate), .write_enable(write_enable),
    .jmp_enable(jmp_enable), .pc_inc(pc_inc), .zero_flag(zero_flag),
    .halted(halted), .retired(retired)
  );

  typedef struct {
    logic [3:0] alu_op;
    logic       ui;
    logic       we;
    logic       jmp;
    logic       pc;
    logic       zf;
    logic       halt;
    logic [1:0] ret;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic       m_zf  = 1'b0;
  logic [1:0] m_ret = 2'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [12:0] all_outs();
    return {instr_req, alu_op, use_immediate, write_enable, jmp_enable, pc_inc,
            zero_flag, halted, retired};
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic az, input int idle);
    int k = 0;
    exp_t e, g;
    logic [3:0] lo;
    logic up0, alu, jmp, jnz, jz, hlt, zf_new, tk, zf_old;
    while (!instr_req && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("req_ready", instr_req, 1);
    repeat (idle) begin
      instr_valid = 1'b0;
      @(negedge clk);
      check("fetch_wait", {instr_req, write_enable, jmp_enable, pc_inc, retired}, {4'b1000, m_ret});
    end
    lo  = op[3:0];
    up0 = (op[5:4] == 2'b00);
    alu = up0 && (lo <= 4'd9);
    jmp = up0 && (lo == 4'd12);
    jnz = up0 && (lo == 4'd13);
    jz  = up0 && (lo == 4'd14);
    hlt = up0 && (lo == 4'd15);
    zf_old = m_zf;
    zf_new = alu ? az : m_zf;
    tk  = jmp || (jnz && !zf_new) || (jz && zf_new);
    e.alu_op = alu ? lo : 4'd0;
    e.ui     = alu ? lo[0] : 1'b0;
    e.we     = alu;
    e.jmp    = tk;
    e.pc     = !hlt && !tk;
    e.zf     = zf_new;
    e.halt   = hlt;
    e.ret    = hlt ? m_ret : m_ret + 2'd1;
    sb.push_back(e);
    m_zf  = zf_new;
    m_ret = e.ret;

    opcode = op;
    instr_valid = 1'b1;
    @(negedge clk);
    // instr_valid stays high with a HALT opcode to show it is ignored outside FETCH.
    opcode = 6'h0f;
    check("decode", {instr_req, alu_op, use_immediate, write_enable, jmp_enable, pc_inc},
          {1'b0, e.alu_op, e.ui, 3'b000});
    alu_zero = az;
    @(negedge clk);
    check("execute", {instr_req, alu_op, use_immediate, write_enable, jmp_enable, pc_inc, zero_flag},
          {1'b0, e.alu_op, e.ui, 3'b000, zf_old});
    @(negedge clk);
    alu_zero = ~az;
    instr_valid = 1'b0;
    g = sb.pop_front();
    check("wb_alu", {alu_op, use_immediate}, {g.alu_op, g.ui});
    check("wb_strobes", {write_enable, jmp_enable, pc_inc}, {g.we, g.jmp, g.pc});
    check("wb_zf", zero_flag, g.zf);
    @(negedge clk);
    check("post", {instr_req, halted, retired, write_enable, jmp_enable, pc_inc},
          {~g.halt, g.halt, g.ret, 3'b000});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_outs", all_outs(), 13'd0);
    end
    rst = 1'b0;
    m_zf  = 1'b0;
    m_ret = 2'd0;
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    opcode = 6'd0;
    alu_zero = 1'b0;
    do_reset();

    run_instr(6'b000011, 1'b1, 5);
    run_instr(6'b000000, 1'b1, 0);
    run_instr(6'b001110, 1'b0, 1);
    run_instr(6'b000010, 1'b0, 0);
    run_instr(6'b001110, 1'b1, 2);
    run_instr(6'b001101, 1'b1, 0);
    run_instr(6'b001100, 1'b0, 0);
    run_instr(6'b000111, 1'b1, 0);
    run_instr(6'b001010, 1'b0, 0);
    run_instr(6'b010000, 1'b0, 0);
    run_instr(6'b001011, 1'b0, 0);
    run_instr(6'b111111, 1'b0, 0);
    run_instr(6'b001101, 1'b0, 0);

    // Abort an ALU op in EXECUTE: no strobe may ever appear for it.
    while (!instr_req) @(negedge clk);
    opcode = 6'b000101;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    alu_zero = 1'b1;
    @(negedge clk);
    do_reset();
    check("abort_zf_ret", {zero_flag, retired, write_enable}, 4'b0000);

    repeat (4) run_instr(6'b001010, 1'b0, 0);

    run_instr(6'b000001, 1'b1, 0);
    run_instr(6'b001111, 1'b0, 0);
    repeat (20) begin
      instr_valid = 1'b1;
      opcode = 6'b000011;
      @(negedge clk);
      check("halt_hold", {instr_req, halted, retired, write_enable, jmp_enable, pc_inc},
            {2'b01, m_ret, 3'b000});
    end
    instr_valid = 1'b0;
    do_reset();
    run_instr(6'b001000, 1'b0, 1);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_control_unit.md
# seq_control_unit

Multi-cycle, parametrised successor to the CPU's single-cycle combinational decoder. Sequences each instruction through FETCH, DECODE, EXECUTE and WRITEBACK, with a valid/ready fetch handshake toward instruction memory. Holds the zero flag internally, adds a HALT instruction and a retired-instruction counter, and drives the ALU, register-file write, PC-increment and jump controls. Sits between instruction memory, the PC, the register file and the ALU.

## Interface
- OPCODE_W, 4: opcode width; must be ≥ 4; only the low 4 bits are decoded, upper bits must be 0 or the instruction is a NOP.
- RETIRE_W, 16: width of the retired-instruction counter.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- instr_req  out  1  request for the next instruction; high in FETCH.
- instr_valid  in  1  instruction memory has an opcode on `opcode`.
- opcode  in  OPCODE_W  opcode; sampled only when `instr_req && instr_valid`.
- alu_zero  in  1  ALU result-is-zero; sampled in EXECUTE.
- alu_op  out  4  ALU operation select.
- use_immediate  out  1  selects the immediate operand for the ALU B input.
- write_enable  out  1  register-file write strobe; one-cycle pulse.
- jmp_enable  out  1  loads the PC from the jump target; one-cycle pulse.
- pc_inc  out  1  increments the PC; one-cycle pulse.
- zero_flag  out  1  architectural zero flag register.
- halted  out  1  core is stopped.
- retired  out  RETIRE_W  count of completed instructions.

## Operation
- Opcode map, on the low 4 bits:
  - 0000–1001: ALU ops. alu_op = opcode; use_immediate = opcode[0].
  - 1100: JMP.
  - 1101: JNZ, taken when zero_flag = 0.
  - 1110: JZ, taken when zero_flag = 1.
  - 1111: HALT.
  - 1010, 1011, and any opcode with nonzero upper bits: NOP.
- FSM states and transitions:
  - FETCH: instr_req = 1. When instr_valid = 1, latch the opcode into `ir` and go to DECODE. Otherwise stay in FETCH indefinitely.
  - DECODE: one cycle. alu_op and use_immediate come from `ir` for ALU ops; they are 0 otherwise. They stay stable through EXECUTE and WRITEBACK.
  - EXECUTE: one cycle. For ALU ops, zero_flag <= alu_zero at the end of the cycle. For all other opcodes, zero_flag holds.
  - WRITEBACK: one cycle.
    - ALU op: write_enable = 1, pc_inc = 1.
    - Taken jump: jmp_enable = 1, pc_inc = 0.
    - Untaken jump or NOP: pc_inc = 1.
    - HALT: no strobes.
    - retired increments for every opcode except HALT.
    - Next state is FETCH, or HALTED for HALT.
  - HALTED: all strobes 0, instr_req = 0, halted = 1. Left only by rst.
- Jump conditions use the zero_flag value at WRITEBACK, i.e. the flag from the most recent ALU op.
- retired wraps from 2^RETIRE_W−1 to 0 without saturating.
- All outputs are functions of state, `ir` and registers only. There is no combinational path from any input to any output.
- Reset value of every output is 0: instr_req, alu_op, use_immediate, write_enable, jmp_enable, pc_inc, zero_flag, halted, retired. State resets to FETCH and ir to 0.
- instr_req rises in the first cycle after rst deasserts.
- rst asserted mid-instruction aborts it immediately: no write_enable, jmp_enable or pc_inc pulse is produced for the aborted instruction, and retired is cleared.

## Timing
- Handshake accepted at edge N (FETCH) → DECODE in cycle N+1, EXECUTE N+2, WRITEBACK N+3, FETCH N+4.
- Best case is 4 cycles per instruction; each cycle instr_valid is low in FETCH adds one cycle.
- instr_req is low outside FETCH. instr_valid outside FETCH is ignored.
- write_enable, jmp_enable and pc_inc are each exactly one cycle wide, in WRITEBACK only, and jmp_enable and pc_inc are mutually exclusive.
- zero_flag updates at the edge ending EXECUTE, so it is visible from WRITEBACK onward.
- retired updates at the edge ending WRITEBACK.

## Test plan
- Reset, then hold instr_valid = 0 for 5 cycles → instr_req = 1 throughout, no strobes, retired = 0; all outputs 0 while rst is high.
- Opcode 0011 with alu_zero = 1 in EXECUTE → alu_op = 0011 and use_immediate = 1 from DECODE; write_enable and pc_inc pulse at N+3; zero_flag = 1; retired = 1.
- Opcode 0000 with alu_zero = 1 then JZ (1110) → jmp_enable pulses and pc_inc stays 0. Then 0010 with alu_zero = 0, then JZ → pc_inc pulses and jmp_enable stays 0. JNZ (1101) after alu_zero = 0 → taken.
- Opcode 1111 → halted = 1 from N+4; instr_req stays 0 for 20 cycles despite instr_valid = 1; retired unchanged. Then rst → back to FETCH with all outputs 0.
- Opcode 1010 and, with OPCODE_W = 6, opcode 010000 → only pc_inc pulses; zero_flag unchanged.
- rst asserted during EXECUTE of an ALU op → no write_enable pulse, zero_flag = 0, retired = 0. With RETIRE_W = 2, 4 NOPs → retired goes 1, 2, 3, 0.
